de_scan_driver14: RTL and testbench
===================================

DE_SCAN_DRIVER14 -- requirements
Module: de_scan_driver14

Interface
REQ-001 SHALL: parameter DWELL_W, default 4, width of the per-channel dwell count.
REQ-002 SHALL: iClk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL: iRst  input  1  reset, synchronous, active-high.
REQ-004 SHALL: iValid  input  1  request to scan one word.
REQ-005 SHALL: oReady  output  1  block can accept a word (high only in IDLE).
REQ-006 SHALL: iData  input  4  bit k is the value driven while channel k is selected.
REQ-007 SHALL: iMask  input  4  bit k=1 enables channel k; disabled channels are skipped.
REQ-008 SHALL: iDwell  input  DWELL_W  cycles per enabled channel; 0 treated as 1.
REQ-009 SHALL: oC  output  1  serial data to the 1:4 demultiplexer data input.
REQ-010 SHALL: oS1, oS0  output  1 each  channel select to the demultiplexer ({oS1,oS0} = channel index).
REQ-011 SHALL: oBusy  output  1  high while a channel is being driven.
REQ-012 SHALL: oDone  output  1  one-cycle pulse at end of each accepted word.

Function
REQ-013 SHALL: FSM states IDLE, SCAN, DONE; all outputs registered.
REQ-014 SHALL: accept occurs on an edge where iValid=1 and oReady=1; iData, iMask and max(iDwell,1) latched at that edge.
REQ-015 SHALL: accept with iMask!=0 -> SCAN, channel pointer = lowest enabled index, dwell counter loaded.
REQ-016 SHALL: accept with iMask==0 -> DONE directly; no channel driven, oBusy stays 0.
REQ-017 SHALL: in SCAN, {oS1,oS0} = pointer, oC = latched data[pointer], oBusy=1, starting the cycle after accept (latency 1).
REQ-018 SHALL: each enabled channel held exactly dwell cycles, then pointer advances to next higher enabled index; no wrap-around within a word.
REQ-019 SHALL: after the highest enabled channel's last dwell cycle -> DONE.
REQ-020 SHALL: in DONE, oDone=1 for exactly one cycle, oBusy=0, oReady=0, then IDLE.
REQ-021 SHALL: in IDLE and DONE, oC=0, oS1=0, oS0=0.
REQ-022 SHALL: oBusy duration per word = popcount(iMask) * max(iDwell,1) cycles.
REQ-023 SHALL: iValid, iData, iMask, iDwell ignored outside IDLE; latched copies unaffected by mid-scan input changes.
REQ-024 SHALL: minimum spacing between accepts = busy cycles + 2 (DONE cycle plus IDLE accept cycle).

Reset
REQ-025 SHALL: iRst=1 at an edge forces IDLE, oReady=1, oC=0, oS1=0, oS0=0, oBusy=0, oDone=0, pointer and dwell counter cleared.
REQ-026 SHALL: iRst overrides a simultaneous accept; reset mid-SCAN or in DONE aborts the word with no oDone pulse.

Verification
REQ-027 SHALL: Reset -> after one edge with iRst=1, all outputs at REQ-025 values; oReady=1.
REQ-028 SHALL: iData=1010, iMask=1111, iDwell=1 -> cycles 1..4 {oS1,oS0}=00,01,10,11 with oC=0,1,0,1; oDone=1 cycle 5; oReady=1 cycle 6.
REQ-029 SHALL: iData=1111, iMask=0101, iDwell=3 -> select 00 for 3 cycles, 10 for 3 cycles, oC=1 throughout, oBusy high 6 cycles, then oDone pulse.
REQ-030 SHALL: iMask=0000 -> oBusy never asserts; oDone=1 the cycle after accept; iDwell=0 with iMask=1000 -> select 11 for exactly 1 cycle.
REQ-031 SHALL: iValid=1 with new iData during SCAN -> ignored, original word completes unchanged; next word accepted only when oReady=1.
REQ-032 SHALL: iRst=1 during cycle 2 of REQ-028 scan -> outputs at reset values the following cycle, no oDone pulse.

Source files
------------

// File: rtl/de_scan_driver14.sv
// Scans the enabled bits of a 4-bit word onto a 1:4 demultiplexer, holding each
// enabled channel for a programmable dwell, then pulses done.
module de_scan_driver14 #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iValid,
    output logic               oReady,
    input  logic [3:0]         iData,
    input  logic [3:0]         iMask,
    input  logic [DWELL_W-1:0] iDwell,
    output logic               oC,
    output logic               oS1,
    output logic               oS0,
    output logic               oBusy,
    output logic               oDone
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [3:0]         data_q, data_nxt;
    logic [3:0]         mask_q, mask_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [2:0]         first_en, next_en;
    logic               ready_nxt, busy_nxt, done_nxt, c_nxt;
    logic [1:0]         sel_nxt;

    // Lowest enabled channel index at or above start; MSB flags a hit.
    function automatic logic [2:0] find_en(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        mask_nxt  = mask_q;
        dwell_nxt = dwell_q;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        first_en  = find_en(iMask, 3'd0);
        next_en   = find_en(mask_q, 3'(ptr) + 3'd1);

        case (state)
            IDLE: begin
                if (iValid) begin
                    data_nxt  = iData;
                    mask_nxt  = iMask;
                    dwell_nxt = (iDwell == '0) ? DWELL_W'(1) : iDwell;
                    if (iMask == 4'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SCAN;
                        ptr_nxt   = first_en[1:0];
                        cnt_nxt   = dwell_nxt - DWELL_W'(1);
                    end
                end
            end
            SCAN: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end else if (next_en[2]) begin
                    ptr_nxt = next_en[1:0];
                    cnt_nxt = dwell_q - DWELL_W'(1);
                end else begin
                    state_nxt = DONE;
                    ptr_nxt   = 2'd0;
                    cnt_nxt   = '0;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs decode the upcoming state so they register alongside it.
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt == SCAN);
        done_nxt  = (state_nxt == DONE);
        sel_nxt   = busy_nxt ? ptr_nxt : 2'd0;
        c_nxt     = busy_nxt & data_nxt[ptr_nxt];
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            data_q  <= 4'd0;
            mask_q  <= 4'd0;
            dwell_q <= '0;
            cnt     <= '0;
            ptr     <= 2'd0;
            oReady  <= 1'b1;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oC      <= 1'b0;
            oS1     <= 1'b0;
            oS0     <= 1'b0;
        end else begin
            state   <= state_nxt;
            data_q  <= data_nxt;
            mask_q  <= mask_nxt;
            dwell_q <= dwell_nxt;
            cnt     <= cnt_nxt;
            ptr     <= ptr_nxt;
            oReady  <= ready_nxt;
            oBusy   <= busy_nxt;
            oDone   <= done_nxt;
            oC      <= c_nxt;
            oS1     <= sel_nxt[1];
            oS0     <= sel_nxt[0];
        end
    end

endmodule

// File: tb/tb_de_scan_driver14.sv
// Scoreboard bench for de_scan_driver14: per-cycle expected output vectors are
// queued when a word is launched and compared cycle by cycle.
module tb_de_scan_driver14;

    localparam int unsigned DWELL_W = 4;

    logic               iClk = 1'b0;
    logic               iRst, iValid;
    logic [3:0]         iData, iMask;
    logic [DWELL_W-1:0] iDwell;
    logic               oReady, oC, oS1, oS0, oBusy, oDone;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Vector layout: {ready, busy, done, s1, s0, c}
    logic [5:0] exp_q[$];
    localparam logic [5:0] V_IDLE = 6'b100000;
    localparam logic [5:0] V_DONE = 6'b001000;

    de_scan_driver14 #(.DWELL_W(DWELL_W)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iData(iData), .iMask(iMask), .iDwell(iDwell),
        .oC(oC), .oS1(oS1), .oS0(oS0), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    function automatic logic [5:0] outs();
        return {oReady, oBusy, oDone, oS1, oS0, oC};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Reference expectation for one word, built from the channel-scan definition.
    task automatic push_word(input logic [3:0] d, input logic [3:0] m, input logic [DWELL_W-1:0] dw);
        int eff;
        eff = (dw == 0) ? 1 : int'(dw);
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                for (int j = 0; j < eff; j++) begin
                    logic [1:0] kk;
                    kk = 2'(k);
                    exp_q.push_back({1'b0, 1'b1, 1'b0, kk[1], kk[0], d[k]});
                end
            end
        end
        exp_q.push_back(V_DONE);
        exp_q.push_back(V_IDLE);
    endtask

    // Launch a word; disturb drives junk requests mid-word; abort_at>0 resets at that cycle.
    task automatic send(input string tag, input logic [3:0] d, input logic [3:0] m,
                        input logic [DWELL_W-1:0] dw, input bit disturb, input int abort_at);
        int cyc;
        int wait_cnt;
        logic [5:0] e;
        wait_cnt = 0;
        while (oReady !== 1'b1 && wait_cnt < 100) begin
            step();
            wait_cnt++;
        end
        check_eq({tag, "_ready"}, 8'(oReady), 8'd1);
        iValid = 1'b1; iData = d; iMask = m; iDwell = dw;
        step();
        iValid = 1'b0;
        iData = ~d; iMask = ~m; iDwell = dw + DWELL_W'(2);
        push_word(d, m, dw);
        cyc = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s_c%0d", tag, cyc), 8'(outs()), 8'(e));
            if (abort_at > 0 && cyc == abort_at) begin
                iRst = 1'b1;
                step();
                iRst = 1'b0;
                check_eq({tag, "_rst"}, 8'(outs()), 8'(V_IDLE));
                step();
                check_eq({tag, "_post_rst"}, 8'(outs()), 8'(V_IDLE));
                exp_q.delete();
                break;
            end
            if (exp_q.size() > 0) begin
                if (disturb && exp_q.size() > 1) begin
                    iValid = 1'b1;
                    iData  = 4'($urandom);
                    iMask  = 4'($urandom);
                    iDwell = DWELL_W'($urandom);
                end else begin
                    iValid = 1'b0;
                end
                step();
            end
            cyc++;
        end
        iValid = 1'b0;
    endtask

    initial begin
        iRst = 1'b1; iValid = 1'b0; iData = 4'd0; iMask = 4'd0; iDwell = '0;
        step();
        check_eq("reset", 8'(outs()), 8'(V_IDLE));
        iRst = 1'b0;
        step();
        check_eq("idle", 8'(outs()), 8'(V_IDLE));

        send("alt", 4'b1010, 4'b1111, 4'd1, 1'b0, 0);
        send("mask0101", 4'b1111, 4'b0101, 4'd3, 1'b0, 0);
        send("mask0", 4'b1111, 4'b0000, 4'd2, 1'b0, 0);
        send("dwell0", 4'b1000, 4'b1000, 4'd0, 1'b0, 0);
        send("disturb", 4'b0110, 4'b1110, 4'd2, 1'b1, 0);
        send("maxdwell", 4'b1001, 4'b1001, 4'd15, 1'b0, 0);
        send("abort", 4'b1010, 4'b1111, 4'd1, 1'b0, 2);

        // Reset wins over a simultaneous accept.
        iValid = 1'b1; iData = 4'b1111; iMask = 4'b1111; iDwell = 4'd1; iRst = 1'b1;
        step();
        iRst = 1'b0; iValid = 1'b0;
        check_eq("rst_vs_accept", 8'(outs()), 8'(V_IDLE));
        step();
        check_eq("rst_vs_accept2", 8'(outs()), 8'(V_IDLE));

        for (int n = 0; n < 6; n++) begin
            logic [3:0] rd, rm;
            logic [DWELL_W-1:0] rw;
            rd = 4'($urandom); rm = 4'($urandom); rw = DWELL_W'($urandom_range(0, 4));
            send($sformatf("rnd%0d", n), rd, rm, rw, n[0], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
